// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// The loader FSM states and frame geometry live here so the top and the packer agree.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_LOAD   = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } loaderState_e;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    // Running payload checksum: plain 8-bit modular sum.
    function automatic logic [7:0] sumAdd(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-lane assembly of little-endian instruction words and the registered
// instruction-memory write port.
module imem_word_packer
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              accept,
    input  logic [7:0]        byteData,
    input  logic [ADDR_W-1:0] wordAddr,
    output logic              laneLast,
    output logic              we,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata
);

    localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  laneCnt_r;
    logic [31:0] shift_r;

    assign laneLast = (laneCnt_r == LAST_LANE);

    // Lane counter, byte shifter and write-port registers; addr/wdata hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            laneCnt_r <= 2'd0;
            shift_r   <= 32'd0;
            we        <= 1'b0;
            addr      <= '0;
            wdata     <= 32'd0;
        end else begin
            we <= 1'b0;
            if (clr) begin
                laneCnt_r <= 2'd0;
            end else if (accept) begin
                laneCnt_r <= laneCnt_r + 2'd1;
                // Bytes arrive LSB first, so each new byte enters at the top.
                shift_r   <= {byteData, shift_r[31:8]};
                if (laneLast) begin
                    we    <= 1'b1;
                    addr  <= wordAddr;
                    wdata <= {byteData, shift_r[31:8]};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory writer: parses a length/payload/checksum byte
// stream and holds the core in reset until a verified image is in memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    input  logic              reload,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              done,
    output logic              error
);

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    loaderState_e      state_r;
    loaderState_e      stateNext_s;
    logic [7:0]        lenLo_r;
    logic [ADDR_W:0]   lenWords_r;
    logic [ADDR_W:0]   wordCnt_r;
    logic [ADDR_W:0]   wordCntInc_s;
    logic [7:0]        sum_r;
    logic [15:0]       lenWord_s;
    logic              xfer_s;
    logic              loadXfer_s;
    logic              laneLast_s;
    logic              restart_s;

    assign xfer_s       = byte_valid && byte_ready;
    assign loadXfer_s   = xfer_s && (state_r == S_LOAD);
    assign restart_s    = reload && ((state_r == S_DONE) || (state_r == S_ERR));
    assign lenWord_s    = {byte_data, lenLo_r};
    assign wordCntInc_s = wordCnt_r + {{ADDR_W{1'b0}}, 1'b1};

    // Ready whenever the FSM is still consuming the frame.
    always_comb begin
        byte_ready = 1'b0;
        if (rst) begin
            byte_ready = 1'b0;
        end else begin
            case (state_r)
                S_LEN_LO, S_LEN_HI, S_LOAD, S_CHECK: byte_ready = 1'b1;
                default:                             byte_ready = 1'b0;
            endcase
        end
    end

    // Frame-parsing next-state logic.
    always_comb begin
        stateNext_s = state_r;
        case (state_r)
            S_LEN_LO: begin
                if (xfer_s) stateNext_s = S_LEN_HI;
                else        stateNext_s = state_r;
            end
            S_LEN_HI: begin
                if (!xfer_s)                             stateNext_s = state_r;
                else if ({1'b0, lenWord_s} > CAPACITY)   stateNext_s = S_ERR;
                else if (lenWord_s == 16'd0)             stateNext_s = S_CHECK;
                else                                     stateNext_s = S_LOAD;
            end
            S_LOAD: begin
                if (loadXfer_s && laneLast_s && (wordCntInc_s == lenWords_r)) stateNext_s = S_CHECK;
                else                                                          stateNext_s = state_r;
            end
            S_CHECK: begin
                if (!xfer_s)                  stateNext_s = state_r;
                else if (byte_data == sum_r)  stateNext_s = S_DONE;
                else                          stateNext_s = S_ERR;
            end
            S_DONE, S_ERR: begin
                if (reload) stateNext_s = S_LEN_LO;
                else        stateNext_s = state_r;
            end
            default: stateNext_s = S_LEN_LO;
        endcase
    end

    // State, counters, checksum and the registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_LEN_LO;
            lenLo_r    <= 8'd0;
            lenWords_r <= '0;
            wordCnt_r  <= '0;
            sum_r      <= 8'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            core_rst   <= 1'b1;
        end else begin
            state_r  <= stateNext_s;
            done     <= (stateNext_s == S_DONE);
            error    <= (stateNext_s == S_ERR);
            core_rst <= (stateNext_s != S_DONE);
            if (xfer_s && (state_r == S_LEN_LO)) lenLo_r <= byte_data;
            if (xfer_s && (state_r == S_LEN_HI)) lenWords_r <= lenWord_s[ADDR_W:0];
            if (restart_s) begin
                wordCnt_r <= '0;
                sum_r     <= 8'd0;
            end else if (loadXfer_s) begin
                sum_r <= sumAdd(sum_r, byte_data);
                if (laneLast_s) wordCnt_r <= wordCntInc_s;
            end
        end
    end

    imem_word_packer #(.ADDR_W(ADDR_W)) uPacker (
        .clk      (clk),
        .rst      (rst),
        .clr      (restart_s),
        .accept   (loadXfer_s),
        .byteData (byte_data),
        .wordAddr (wordCnt_r[ADDR_W-1:0]),
        .laneLast (laneLast_s),
        .we       (imem_we),
        .addr     (imem_addr),
        .wdata    (imem_wdata)
    );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames are modelled from the byte-stream
// rules, expected writes are queued at transfer time and a monitor checks them.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              reload = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              error;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_ready(byte_ready), .reload(reload), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                due;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    wr_t  expQ[$];
    int   errors = 0;
    int   checks = 0;
    int   negCnt = 0;
    logic [7:0] basicBytes [0:10] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                                      8'h13, 8'h01, 8'h10, 8'h00, 8'h07};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the head of the scoreboard.
    initial begin
        logic prevWe;
        wr_t  e;
        prevWe = 1'b0;
        forever begin
            @(negedge clk);
            negCnt++;
            if (imem_we === 1'b1) begin
                check("we_pulse_width", prevWe, 1'b0);
                if (expQ.size() == 0) begin
                    check("stray_write_addr", imem_addr, 64'hFFFF_FFFF);
                end else begin
                    e = expQ.pop_front();
                    check("wr_addr", imem_addr, e.addr);
                    check("wr_data", imem_wdata, e.data);
                    check("wr_cycle", negCnt, e.due);
                end
            end
            prevWe = imem_we;
        end
    end

    // Drive one frame; the reference model queues each completed word as it transfers.
    task automatic send_frame(input logic [7:0] fr[$], input int gapPct,
                              output int cyc, output logic expDone, output logic expErr);
        int  n;
        int  s;
        int  j;
        int  guard;
        bit  sent;
        bit  ovf;
        wr_t e;
        n   = int'(fr[0]) + 256 * int'(fr[1]);
        ovf = (n > (1 << ADDR_W));
        s   = 0;
        if (!ovf) begin
            for (int k = 0; k < 4 * n && (HDR_BYTES + k) < fr.size(); k++) s += int'(fr[HDR_BYTES + k]);
        end
        s       = s % 256;
        expDone = !ovf && (fr.size() > HDR_BYTES + 4 * n) && (int'(fr[HDR_BYTES + 4 * n]) == s);
        expErr  = !expDone;
        cyc     = 0;
        for (int i = 0; i < fr.size(); i++) begin
            sent  = 1'b0;
            guard = 0;
            while (!sent) begin
                @(negedge clk);
                cyc++;
                guard++;
                if (gapPct > 0 && $urandom_range(99, 0) < gapPct) begin
                    byte_valid = 1'b0;
                end else begin
                    byte_valid = 1'b1;
                    byte_data  = fr[i];
                    if (byte_ready) begin
                        @(posedge clk);
                        sent = 1'b1;
                        j = i - HDR_BYTES;
                        if (!ovf && j >= 0 && j < 4 * n && (j % 4) == 3) begin
                            e.due  = negCnt + 1;
                            e.addr = ADDR_W'(j / 4);
                            e.data = {fr[i], fr[i-1], fr[i-2], fr[i-3]};
                            expQ.push_back(e);
                        end
                    end
                end
                if (!sent && guard > 200) begin
                    check("byte_ready_timeout", byte_ready, 1'b1);
                    byte_valid = 1'b0;
                    return;
                end
            end
        end
    endtask

    task automatic check_status(input string tag, input logic expDone, input logic expErr);
        check({tag, "_done"}, done, expDone);
        check({tag, "_error"}, error, expErr);
        check({tag, "_core_rst"}, core_rst, !expDone);
        check({tag, "_byte_ready"}, byte_ready, !(expDone || expErr));
    endtask

    task automatic finish_frame(input string tag, input logic expDone, input logic expErr);
        @(negedge clk);
        byte_valid = 1'b0;
        check_status(tag, expDone, expErr);
        check({tag, "_writes_drained"}, expQ.size(), 0);
    endtask

    task automatic do_reload(input string tag);
        @(negedge clk);
        reload = 1'b1;
        @(negedge clk);
        reload = 1'b0;
        check_status({tag, "_reload"}, 1'b0, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, imem_we, 1'b0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_core_rst"}, core_rst, 1'b1);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_error"}, error, 1'b0);
        check({tag, "_byte_ready"}, byte_ready, 1'b0);
    endtask

    initial begin
        logic [7:0] fr[$];
        int         cyc;
        int         n;
        int         s;
        logic       eDone;
        logic       eErr;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_byte_ready", byte_ready, 1'b1);

        // Basic load, back-to-back: done visible in cycle 12.
        fr.delete();
        for (int i = 0; i < 11; i++) fr.push_back(basicBytes[i]);
        send_frame(fr, 0, cyc, eDone, eErr);
        check("throughput_cycles", cyc, 11);
        finish_frame("basic", 1'b1, 1'b0);
        check("hold_addr", imem_addr, 1);
        check("hold_wdata", imem_wdata, 32'h0010_0113);
        do_reload("basic");

        // Bad checksum, then a correct frame under backpressure.
        fr[10] = 8'h08;
        send_frame(fr, 0, cyc, eDone, eErr);
        finish_frame("badchk", 1'b0, 1'b1);
        do_reload("badchk");
        fr[10] = 8'h07;
        send_frame(fr, 40, cyc, eDone, eErr);
        finish_frame("gaps", 1'b1, 1'b0);
        do_reload("gaps");

        // Zero-length image.
        fr.delete();
        fr.push_back(8'h00); fr.push_back(8'h00); fr.push_back(8'h00);
        send_frame(fr, 0, cyc, eDone, eErr);
        finish_frame("len0", 1'b1, 1'b0);
        do_reload("len0");

        // Length overflow: N = 0x0401.
        fr.delete();
        fr.push_back(8'h01); fr.push_back(8'h04);
        send_frame(fr, 0, cyc, eDone, eErr);
        finish_frame("overflow", 1'b0, 1'b1);
        do_reload("overflow");

        // Reset after two payload bytes of word 1.
        fr.delete();
        for (int i = 0; i < 8; i++) fr.push_back(basicBytes[i]);
        send_frame(fr, 0, cyc, eDone, eErr);
        @(negedge clk);
        rst = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk);
        check_reset_values("midword_rst");
        rst = 1'b0;
        check("midword_no_pending", expQ.size(), 0);
        fr.delete();
        for (int i = 0; i < 11; i++) fr.push_back(basicBytes[i]);
        send_frame(fr, 0, cyc, eDone, eErr);
        finish_frame("after_rst", 1'b1, 1'b0);
        do_reload("after_rst");

        // Randomized images with random gaps and occasional corrupt checksums.
        for (int t = 0; t < 6; t++) begin
            fr.delete();
            n = $urandom_range(8, 1);
            fr.push_back(8'(n)); fr.push_back(8'h00);
            s = 0;
            for (int k = 0; k < 4 * n; k++) begin
                fr.push_back(8'($urandom_range(255, 0)));
                s += int'(fr[fr.size() - 1]);
            end
            if ($urandom_range(99, 0) < 30) fr.push_back(8'((s + int'($urandom_range(255, 1))) % 256));
            else                            fr.push_back(8'(s % 256));
            send_frame(fr, 30, cyc, eDone, eErr);
            finish_frame("random", eDone, eErr);
            do_reload("random");
        end

        // Full-capacity image: last write lands at the top address.
        fr.delete();
        fr.push_back(8'h00); fr.push_back(8'h04);
        s = 0;
        for (int k = 0; k < 4 * 1024; k++) begin
            fr.push_back(8'($urandom_range(255, 0)));
            s += int'(fr[fr.size() - 1]);
        end
        fr.push_back(8'(s % 256));
        send_frame(fr, 0, cyc, eDone, eErr);
        finish_frame("full", 1'b1, 1'b0);
        check("full_last_addr", imem_addr, 1023);
        do_reload("full");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
